nav_sequencer: RTL and testbench

Controller that sequences the three-axis position datapath and the velocity-mode selector. It produces the one-hot `pos_mode` select (reset / sublight / jump) and the one-hot flight `mode` (halt / attack / defense / stealth). It accepts jump and mode-change requests through valid/ack handshakes and enforces a charge delay before each jump and a cooldown after it. It sits between the command interface and the Position/Velocity blocks.

---
 rtl/nav_pkg.sv | 25 ++
 rtl/nav_timer.sv | 30 +++
 rtl/nav_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_nav_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared navigation definitions: position-mux selects, flight modes and sequencer state encodings.
package nav_pkg;

  localparam logic [3:0] POS_RESET  = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_JUMP   = 4'b0100;

  localparam logic [3:0] MODE_HALT    = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  typedef enum logic [2:0] {
    ST_HOME     = 3'b000,
    ST_CRUISE   = 3'b001,
    ST_CHARGE   = 3'b010,
    ST_JUMP     = 3'b011,
    ST_COOLDOWN = 3'b100
  } nav_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/nav_timer.sv
// Loadable down-counter shared by the charge and cooldown phases; done flags a zero count.
module nav_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  // Load has priority over decrement; the caller never decrements at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/nav_sequencer.sv
// Jump/flight-mode sequencer: arbitrates jump and mode requests, times charge and cooldown,
// and drives the position-mux select and velocity mode for the downstream datapath.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int K               = 16,
  parameter int CHARGE_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int CW              = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_home,
  input  logic           jump_req,
  input  logic [3*K-1:0] jump_target,
  output logic           jump_ack,
  input  logic           mode_req,
  input  logic [3:0]     mode_in,
  output logic           mode_ack,
  output logic           req_err,
  output logic [3:0]     pos_mode,
  output logic [3:0]     mode,
  output logic [3*K-1:0] jump_position,
  output logic           busy,
  output logic [2:0]     state_o
);

  localparam logic [CW-1:0] CHARGE_LOAD   = CW'(CHARGE_CYCLES - 1);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_CYCLES - 1);

  nav_state_t     r_state;
  logic [3:0]     r_pos_mode;
  logic [3:0]     r_mode;
  logic [3:0]     r_saved_mode;
  logic [3*K-1:0] r_jump_pos;
  logic           r_jump_ack;
  logic           r_mode_ack;
  logic           r_req_err;
  logic           r_busy;

  logic           w_load;
  logic [CW-1:0]  w_load_val;
  logic           w_dec;
  logic           w_done;

  nav_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .o_done    (w_done)
  );

  // Timer control mirrors the transitions taken by the state register below.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      ST_CRUISE: begin
        if (!cmd_home && jump_req) begin
          w_load     = 1'b1;
          w_load_val = CHARGE_LOAD;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_CHARGE: begin
        w_dec = !w_done;
      end
      ST_JUMP: begin
        w_load     = 1'b1;
        w_load_val = COOLDOWN_LOAD;
      end
      ST_COOLDOWN: begin
        if (cmd_home) begin
          w_load = 1'b1;
        end else begin
          w_dec = !w_done;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Sequencer state and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HOME;
      r_pos_mode   <= POS_RESET;
      r_mode       <= MODE_HALT;
      r_saved_mode <= MODE_HALT;
      r_jump_pos   <= '0;
      r_jump_ack   <= 1'b0;
      r_mode_ack   <= 1'b0;
      r_req_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_jump_ack <= 1'b0;
      r_mode_ack <= 1'b0;
      r_req_err  <= 1'b0;
      case (r_state)
        ST_HOME: begin
          r_state    <= ST_CRUISE;
          r_pos_mode <= POS_NORMAL;
          r_busy     <= 1'b0;
          if (mode_req && is_onehot4(mode_in)) begin
            r_mode     <= mode_in;
            r_mode_ack <= 1'b1;
          end
          r_req_err <= jump_req || (mode_req && !is_onehot4(mode_in));
        end
        ST_CRUISE: begin
          if (cmd_home) begin
            r_state    <= ST_HOME;
            r_pos_mode <= POS_RESET;
            r_req_err  <= jump_req || mode_req;
          end else begin
            if (mode_req && is_onehot4(mode_in)) begin
              r_mode     <= mode_in;
              r_mode_ack <= 1'b1;
            end
            r_req_err <= mode_req && !is_onehot4(mode_in);
            // A simultaneous mode change and jump are both accepted on this edge.
            if (jump_req) begin
              r_jump_pos <= jump_target;
              r_jump_ack <= 1'b1;
              r_state    <= ST_CHARGE;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_CHARGE: begin
          r_req_err <= jump_req || mode_req;
          if (w_done) begin
            r_state    <= ST_JUMP;
            r_pos_mode <= POS_JUMP;
          end
        end
        ST_JUMP: begin
          r_req_err    <= jump_req || mode_req;
          r_state      <= ST_COOLDOWN;
          r_pos_mode   <= POS_NORMAL;
          r_saved_mode <= r_mode;
          r_mode       <= MODE_HALT;
        end
        ST_COOLDOWN: begin
          r_req_err <= jump_req || mode_req;
          if (cmd_home) begin
            r_state    <= ST_HOME;
            r_pos_mode <= POS_RESET;
            r_mode     <= r_saved_mode;
            r_busy     <= 1'b0;
          end else if (w_done) begin
            r_state <= ST_CRUISE;
            r_mode  <= r_saved_mode;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_HOME;
          r_pos_mode <= POS_RESET;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign jump_ack      = r_jump_ack;
  assign mode_ack      = r_mode_ack;
  assign req_err       = r_req_err;
  assign pos_mode      = r_pos_mode;
  assign mode          = r_mode;
  assign jump_position = r_jump_pos;
  assign busy          = r_busy;
  assign state_o       = r_state;

endmodule

// File: tb/tb_nav_sequencer.sv
// Self-checking bench for nav_sequencer: timeline-based reference model plus directed literal checks.
module tb_nav_sequencer;

  localparam int K = 16;
  localparam int C = 8;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_home = 1'b0;
  logic           jump_req = 1'b0;
  logic [3*K-1:0] jump_target = '0;
  logic           mode_req = 1'b0;
  logic [3:0]     mode_in = 4'b0000;
  logic           jump_ack, mode_ack, req_err, busy;
  logic [3:0]     pos_mode, mode;
  logic [3*K-1:0] jump_position;
  logic [2:0]     state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nav_sequencer #(.K(K), .CHARGE_CYCLES(C), .COOLDOWN_CYCLES(D), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_home(cmd_home),
    .jump_req(jump_req), .jump_target(jump_target), .jump_ack(jump_ack),
    .mode_req(mode_req), .mode_in(mode_in), .mode_ack(mode_ack),
    .req_err(req_err), .pos_mode(pos_mode), .mode(mode),
    .jump_position(jump_position), .busy(busy), .state_o(state_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: phase derived from cycles elapsed since the accepted jump.
  typedef enum {P_HOME, P_CRUISE, P_CHG, P_JMP, P_CD} ph_t;

  int             cyc = 0;
  int             m_jump_t = -1;
  bit             m_home = 1'b1;
  logic [3:0]     m_mode = 4'b0001;
  logic [3:0]     m_saved = 4'b0001;
  logic [3*K-1:0] m_jpos = '0;
  logic           e_jack = 1'b0, e_mack = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [3:0]     e_pos = 4'b0001;
  logic [2:0]     e_state = 3'd0;

  function automatic ph_t phase_at(input int n);
    int e;
    if (m_home) return P_HOME;
    if (m_jump_t < 0) return P_CRUISE;
    e = n - m_jump_t;
    if (e >= 1 && e <= C) return P_CHG;
    if (e == C + 1) return P_JMP;
    if (e <= C + D + 1) return P_CD;
    return P_CRUISE;
  endfunction

  task automatic model_mode_req();
    if (mode_req) begin
      if ($countones(mode_in) == 1) begin
        m_mode = mode_in;
        e_mack = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    ph_t cur, nxt;
    if (!rst_n) begin
      m_home = 1'b1; m_jump_t = -1; m_mode = 4'b0001; m_saved = 4'b0001; m_jpos = '0;
      e_jack = 1'b0; e_mack = 1'b0; e_err = 1'b0; e_busy = 1'b0;
      e_pos = 4'b0001; e_state = 3'd0;
      cyc++;
      return;
    end
    cur = phase_at(cyc);
    e_jack = 1'b0; e_mack = 1'b0; e_err = 1'b0;
    case (cur)
      P_HOME: begin
        m_home = 1'b0;
        model_mode_req();
        if (jump_req) e_err = 1'b1;
      end
      P_CRUISE: begin
        if (cmd_home) begin
          m_home = 1'b1;
          e_err = jump_req | mode_req;
        end else begin
          model_mode_req();
          if (jump_req) begin
            m_jpos = jump_target; e_jack = 1'b1; m_jump_t = cyc;
          end
        end
      end
      P_CHG: e_err = jump_req | mode_req;
      P_JMP: begin
        e_err = jump_req | mode_req;
        m_saved = m_mode; m_mode = 4'b0001;
      end
      default: begin
        e_err = jump_req | mode_req;
        if (cmd_home) begin
          m_home = 1'b1; m_jump_t = -1; m_mode = m_saved;
        end else if (cyc - m_jump_t == C + D + 1) begin
          m_jump_t = -1; m_mode = m_saved;
        end
      end
    endcase
    cyc++;
    nxt = phase_at(cyc);
    e_pos   = (nxt == P_HOME) ? 4'b0001 : (nxt == P_JMP) ? 4'b0100 : 4'b0010;
    e_busy  = (nxt == P_CHG) || (nxt == P_JMP) || (nxt == P_CD);
    e_state = (nxt == P_HOME) ? 3'd0 : (nxt == P_CRUISE) ? 3'd1 :
              (nxt == P_CHG) ? 3'd2 : (nxt == P_JMP) ? 3'd3 : 3'd4;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_jump_ack", jump_ack, e_jack);
      chk("m_mode_ack", mode_ack, e_mack);
      chk("m_req_err",  req_err,  e_err);
      chk("m_pos_mode", pos_mode, e_pos);
      chk("m_mode",     mode,     m_mode);
      chk("m_jpos",     jump_position, m_jpos);
      chk("m_busy",     busy,     e_busy);
      chk("m_state",    state_o,  e_state);
    end
  end

  logic [3*K-1:0] j321, jaa, j55, j77, j999;

  initial begin
    j321 = {16'd3, 16'd2, 16'd1};
    jaa  = {16'd0, 16'd0, 16'h00AA};
    j55  = {16'd0, 16'd0, 16'h0055};
    j77  = {16'd0, 16'd0, 16'h0077};
    j999 = {16'd9, 16'd9, 16'd9};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", pos_mode, 4'b0001);
    chk("rst_mode", mode, 4'b0001);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_o, 3'd0);
    chk("rst_jpos", jump_position, 48'd0);
    chk("rst_pulses", {jump_ack, mode_ack, req_err}, 3'b000);

    // Reset release: one HOME cycle then CRUISE
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_home_pos", pos_mode, 4'b0001);
    @(negedge clk);
    chk("rel_cruise_pos", pos_mode, 4'b0010);
    chk("rel_cruise_state", state_o, 3'd1);

    // Mode change accepted, then malformed ones rejected
    mode_req = 1'b1; mode_in = 4'b0100;
    @(negedge clk);
    chk("mode_ack", mode_ack, 1'b1);
    chk("mode_val", mode, 4'b0100);
    mode_in = 4'b0110;
    @(negedge clk);
    chk("mode_bad_err", {req_err, mode_ack}, 2'b10);
    chk("mode_bad_keep", mode, 4'b0100);
    mode_in = 4'b0000;
    @(negedge clk);
    chk("mode_zero_err", req_err, 1'b1);
    mode_req = 1'b0;
    @(negedge clk);
    chk("mode_err_clear", req_err, 1'b0);

    // Jump timeline with rejected requests and ignored home during charge
    jump_target = j321; jump_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("j_ack", jump_ack, 1'b1);
        chk("j_busy", busy, 1'b1);
        jump_req = 1'b0;
      end
      if (k == 3) begin jump_req = 1'b1; jump_target = j999; end
      if (k == 4) begin
        chk("chg_jump_err", req_err, 1'b1);
        chk("chg_jpos_keep", jump_position, j321);
        jump_req = 1'b0;
        mode_req = 1'b1; mode_in = 4'b0010;
      end
      if (k == 5) begin
        chk("chg_mode_err", req_err, 1'b1);
        chk("chg_mode_keep", mode, 4'b0100);
        mode_req = 1'b0; cmd_home = 1'b1;
      end
      if (k == 6) begin
        chk("chg_home_ignored", state_o, 3'd2);
        cmd_home = 1'b0;
      end
      if (k == 9) begin
        chk("jump_pos_mode", pos_mode, 4'b0100);
        chk("jump_state", state_o, 3'd3);
        chk("jump_jpos", jump_position, j321);
      end
      if (k >= 10 && k <= 13) chk("cd_halt", mode, 4'b0001);
      if (k == 11) jump_req = 1'b1;
      if (k == 12) begin
        chk("cd_jump_err", req_err, 1'b1);
        jump_req = 1'b0;
      end
      if (k == 14) begin
        chk("cd_restore_mode", mode, 4'b0100);
        chk("cd_to_cruise", state_o, 3'd1);
        chk("cd_busy_low", busy, 1'b0);
      end
    end

    // Home during cooldown, then a jump attempt while in HOME
    jump_target = jaa; jump_req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) jump_req = 1'b0;
      if (k == 11) begin
        cmd_home = 1'b1; mode_req = 1'b1; mode_in = 4'b0010;
      end
      if (k == 12) begin
        chk("home_state", state_o, 3'd0);
        chk("home_pos", pos_mode, 4'b0001);
        chk("home_err", req_err, 1'b1);
        chk("home_mode_restore", mode, 4'b0100);
        cmd_home = 1'b0; mode_req = 1'b0; jump_req = 1'b1;
      end
      if (k == 13) begin
        chk("home_jump_err", req_err, 1'b1);
        chk("home_to_cruise", state_o, 3'd1);
        chk("home_jpos_keep", jump_position, jaa);
        jump_req = 1'b0;
      end
    end

    // Simultaneous jump and mode change
    @(negedge clk);
    jump_target = j55; jump_req = 1'b1; mode_req = 1'b1; mode_in = 4'b1000;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("both_acks", {jump_ack, mode_ack}, 2'b11);
        chk("both_mode", mode, 4'b1000);
        jump_req = 1'b0; mode_req = 1'b0;
      end
      if (k == 14) chk("both_restore", mode, 4'b1000);
    end

    // Reset mid-charge
    jump_target = j77; jump_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) jump_req = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", state_o, 3'd0);
    chk("midrst_pos", pos_mode, 4'b0001);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_jpos", jump_position, 48'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_jump_after_rst", pos_mode, 4'b0010);
    end

    // Fresh jump after reset: full timeline through the model
    jump_target = j321; jump_req = 1'b1;
    @(negedge clk); jump_req = 1'b0;
    repeat (16) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
